// File: rtl/iob_dma_arb_if.sv
// rtl/iob_dma_arb_if.sv - native valid/ready memory bus shared by the DMA arbiter ports
interface iob_dma_arb_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  lock;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;

  modport master (output valid, addr, wdata, wstrb, lock, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, lock, output ready, rdata);
endinterface

// File: rtl/iob_dma_arb.sv
// rtl/iob_dma_arb.sv - two-master arbiter with lock; IOB_DMA_ARB_RR_EN selects round-robin ties
module iob_dma_arb #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  iob_dma_arb_if.slave         m0,
  iob_dma_arb_if.slave         m1,
  iob_dma_arb_if.master        s,
  output logic [1:0]           gnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t state_q, state_d;
  logic   sel_q, sel_d;    // 0 = m0, 1 = m1
  logic   last_q, last_d;  // master of the last completed non-locked transfer
  logic   tie_sel;

  logic                g_valid;
  logic                g_lock;
  logic [ADDR_W-1:0]   g_addr;
  logic [DATA_W-1:0]   g_wdata;
  logic [DATA_W/8-1:0] g_wstrb;

`ifdef IOB_DMA_ARB_RR_EN
  assign tie_sel = ~last_q;
`else
  assign tie_sel = 1'b0;
`endif

  always_comb begin
    g_valid = sel_q ? m1.valid : m0.valid;
    g_lock  = sel_q ? m1.lock  : m0.lock;
    g_addr  = sel_q ? m1.addr  : m0.addr;
    g_wdata = sel_q ? m1.wdata : m0.wdata;
    g_wstrb = sel_q ? m1.wstrb : m0.wstrb;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    last_d   = last_q;
    gnt      = 2'b00;
    s.valid  = 1'b0;
    s.addr   = '0;
    s.wdata  = '0;
    s.wstrb  = '0;
    s.lock   = 1'b0;
    m0.ready = 1'b0;
    m1.ready = 1'b0;
    m0.rdata = s.rdata;
    m1.rdata = s.rdata;

    case (state_q)
      IDLE: begin
        if (m0.valid || m1.valid) begin
          state_d = GRANT;
          sel_d   = (m0.valid && m1.valid) ? tie_sel : m1.valid;
        end
      end
      GRANT: begin
        gnt      = sel_q ? 2'b10 : 2'b01;
        s.valid  = g_valid;
        s.addr   = g_addr;
        s.wdata  = g_wdata;
        s.wstrb  = g_wstrb;
        s.lock   = g_lock;
        m0.ready = ~sel_q & s.ready;
        m1.ready =  sel_q & s.ready;
        if (g_valid && s.ready) begin
          if (!g_lock) begin
            state_d = IDLE;
            last_d  = sel_q;
          end
        end else if (!g_valid && !g_lock) begin
          // abandoned request: release without crediting the master
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_iob_dma_arb.sv
// tb/tb_iob_dma_arb.sv - directed vector bench for iob_dma_arb
module tb_iob_dma_arb;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
`ifdef IOB_DMA_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [23:0] M0_ADDR  = 24'h000010;
  localparam logic [31:0] M0_WDATA = 32'hA5A5_0000;
  localparam logic [31:0] RDATA    = 32'h0000_CAFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] gnt;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  iob_dma_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  iob_dma_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();
  iob_dma_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) s_if ();

  iob_dma_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .gnt   (gnt)
  );

  typedef struct {
    logic        m0v, m0l, m1v, m1l, sr;
    logic [23:0] a1;
    logic [31:0] w1;
    logic [1:0]  egnt;
    logic        esv, er0, er1;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic m0v, m0l, m1v, m1l, sr,
                              input logic [23:0] a1, input logic [31:0] w1,
                              input logic [1:0] egnt, input logic esv, er0, er1);
    vec_t v;
    v.m0v = m0v; v.m0l = m0l; v.m1v = m1v; v.m1l = m1l; v.sr = sr;
    v.a1 = a1; v.w1 = w1; v.egnt = egnt; v.esv = esv; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [23:0] ea;
    logic [31:0] ew;
    logic [3:0]  es;
    int n;

    m0_if.valid = 1'b1; m0_if.lock = 1'b0; m0_if.addr = M0_ADDR;
    m0_if.wdata = M0_WDATA; m0_if.wstrb = 4'h0;
    m1_if.valid = 1'b0; m1_if.lock = 1'b0; m1_if.addr = 24'h40;
    m1_if.wdata = 32'h0; m1_if.wstrb = 4'hF;
    s_if.ready = 1'b1; s_if.rdata = RDATA;

    // reset state, with a request pending to show nothing leaks through
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt", gnt, 2'b00);
    chk("rst s_valid", s_if.valid, 1'b0);
    chk("rst s_addr", s_if.addr, 24'h0);
    chk("rst s_wdata", s_if.wdata, 32'h0);
    chk("rst m0_ready", m0_if.ready, 1'b0);
    chk("rst m1_ready", m1_if.ready, 1'b0);
    m0_if.valid = 1'b0;
    rst_n = 1'b1;

    // 6 tied transfers, 12 cycles
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) vt.push_back(mk(1,0,1,0,1, 24'h40, 32'h0, 2'b00, 0,0,0));
      else begin
        g = RR ? (((k / 2) % 2) ? 2'b10 : 2'b01) : 2'b01;
        vt.push_back(mk(1,0,1,0,1, 24'h40, 32'h0, g, 1, g[0], g[1]));
      end
    end
    // single m0 read
    vt.push_back(mk(1,0,0,0,1, 24'h40, 32'h0, 2'b00, 0,0,0));
    vt.push_back(mk(1,0,0,0,1, 24'h40, 32'h0, 2'b01, 1,1,0));
    vt.push_back(mk(0,0,0,0,1, 24'h40, 32'h0, 2'b00, 0,0,0));
    // m1 locked 4-beat write with m0 waiting
    vt.push_back(mk(0,0,1,1,1, 24'h40, 32'h1, 2'b00, 0,0,0));
    vt.push_back(mk(1,0,1,1,1, 24'h40, 32'h1, 2'b10, 1,0,1));
    vt.push_back(mk(1,0,1,1,1, 24'h44, 32'h2, 2'b10, 1,0,1));
    vt.push_back(mk(1,0,1,1,1, 24'h48, 32'h3, 2'b10, 1,0,1));
    vt.push_back(mk(1,0,1,0,1, 24'h4C, 32'h4, 2'b10, 1,0,1));
    vt.push_back(mk(1,0,0,0,1, 24'h4C, 32'h4, 2'b00, 0,0,0));
    // m0 with three wait states
    vt.push_back(mk(1,0,0,0,0, 24'h4C, 32'h4, 2'b01, 1,0,0));
    vt.push_back(mk(1,0,0,0,0, 24'h4C, 32'h4, 2'b01, 1,0,0));
    vt.push_back(mk(1,0,0,0,0, 24'h4C, 32'h4, 2'b01, 1,0,0));
    vt.push_back(mk(1,0,0,0,1, 24'h4C, 32'h4, 2'b01, 1,1,0));
    vt.push_back(mk(0,0,0,0,1, 24'h4C, 32'h4, 2'b00, 0,0,0));
    // unlocked drop must not update last_gnt
    vt.push_back(mk(0,0,1,0,0, 24'h40, 32'h9, 2'b00, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, 24'h40, 32'h9, 2'b10, 0,0,0));
    vt.push_back(mk(1,0,1,0,1, 24'h40, 32'h9, 2'b00, 0,0,0));
    g = RR ? 2'b10 : 2'b01;
    vt.push_back(mk(1,0,1,0,1, 24'h40, 32'h9, g, 1, g[0], g[1]));
    vt.push_back(mk(0,0,0,0,0, 24'h40, 32'h9, 2'b00, 0,0,0));
    // locked drop holds the grant; m1 is never forwarded meanwhile
    vt.push_back(mk(1,1,0,0,0, 24'h40, 32'h9, 2'b00, 0,0,0));
    vt.push_back(mk(0,1,0,0,0, 24'h40, 32'h9, 2'b01, 0,0,0));
    vt.push_back(mk(0,1,1,0,0, 24'h40, 32'h9, 2'b01, 0,0,0));
    vt.push_back(mk(1,0,1,0,1, 24'h40, 32'h9, 2'b01, 1,1,0));
    vt.push_back(mk(0,0,1,0,0, 24'h40, 32'h9, 2'b00, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, 24'h40, 32'h9, 2'b10, 0,0,0));
    vt.push_back(mk(0,0,0,0,0, 24'h40, 32'h9, 2'b00, 0,0,0));

    foreach (vt[i]) begin
      @(posedge clk);
      #1;
      m0_if.valid = vt[i].m0v; m0_if.lock = vt[i].m0l;
      m1_if.valid = vt[i].m1v; m1_if.lock = vt[i].m1l;
      m1_if.addr  = vt[i].a1;  m1_if.wdata = vt[i].w1;
      s_if.ready  = vt[i].sr;
      @(negedge clk);
      ea = (vt[i].egnt == 2'b01) ? M0_ADDR  : (vt[i].egnt == 2'b10) ? vt[i].a1 : 24'h0;
      ew = (vt[i].egnt == 2'b01) ? M0_WDATA : (vt[i].egnt == 2'b10) ? vt[i].w1 : 32'h0;
      es = (vt[i].egnt == 2'b10) ? 4'hF : 4'h0;
      chk($sformatf("v%0d gnt", i), gnt, vt[i].egnt);
      chk($sformatf("v%0d s_valid", i), s_if.valid, vt[i].esv);
      chk($sformatf("v%0d m0_ready", i), m0_if.ready, vt[i].er0);
      chk($sformatf("v%0d m1_ready", i), m1_if.ready, vt[i].er1);
      chk($sformatf("v%0d s_addr", i), s_if.addr, ea);
      chk($sformatf("v%0d s_wdata", i), s_if.wdata, ew);
      chk($sformatf("v%0d s_wstrb", i), s_if.wstrb, es);
      if (vt[i].er0) chk($sformatf("v%0d m0_rdata", i), m0_if.rdata, RDATA);
      if (vt[i].er1) chk($sformatf("v%0d m1_rdata", i), m1_if.rdata, RDATA);
    end

    // asynchronous reset while m1 is stalled by the slave
    @(posedge clk);
    #1;
    m0_if.valid = 1'b0; m1_if.valid = 1'b1; m1_if.lock = 1'b0; s_if.ready = 1'b0;
    n = 0;
    while (gnt !== 2'b10 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid gnt before reset", gnt, 2'b10);
    chk("mid s_valid before reset", s_if.valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst gnt", gnt, 2'b00);
    chk("mid rst s_valid", s_if.valid, 1'b0);
    chk("mid rst m0_ready", m0_if.ready, 1'b0);
    chk("mid rst m1_ready", m1_if.ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m0_if.valid = 1'b1; m1_if.valid = 1'b1; s_if.ready = 1'b1;
    @(negedge clk);
    chk("post rst tie gnt", gnt, 2'b01);
    chk("post rst tie m0_ready", m0_if.ready, 1'b1);
    chk("post rst tie m1_ready", m1_if.ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
